// File: rtl/conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// conv_window_scheduler
//
// Walks a K x K window over every output pixel of a feature map. For each tap
// it issues an IFMD RAM read (rd_en/rd_addr) together with the kernel
// coefficient index (tap_idx). One cycle later, once the RAM data is valid, it
// drives the MAC strobes (mac_en/mac_clear/mac_last/tap_zero). After the last
// tap of a window it presents the output address on a valid/ready handshake.
// When the final output is accepted it pulses done for one cycle.
//
// Optional feature macro: CONV_PAD_EN
//   defined   : "same" padding. OUT_W = IMG_W, OUT_H = IMG_H. Taps that fall
//               outside the image issue no read and raise tap_zero instead.
//   undefined : "valid" convolution. OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1.
//               Every tap reads and tap_zero is tied low.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   frame start level, sampled only in IDLE
//   rd_en      out  IFMD RAM read strobe
//   rd_addr    out  IFMD address, row*IMG_W+col
//   tap_idx    out  kernel coefficient index, ky*K+kx (with rd_en cycle)
//   mac_en     out  MAC accumulate (RAM data valid this cycle)
//   mac_clear  out  first tap of a window: MAC loads instead of accumulating
//   mac_last   out  final tap of a window
//   tap_zero   out  padding tap: MAC adds zero
//   out_valid  out  output result ready
//   out_addr   out  output address, oy*OUT_W+ox
//   out_ready  in   output RAM accepts
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the final output is accepted
// -----------------------------------------------------------------------------
module conv_window_scheduler #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 8,
    parameter int TAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              mac_en,
    output logic              mac_clear,
    output logic              mac_last,
    output logic              tap_zero,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

`ifdef CONV_PAD_EN
    localparam int OUT_W = IMG_W;
    localparam int OUT_H = IMG_H;
    localparam int PAD   = (K - 1) / 2;
`else
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int PAD   = 0;
`endif

    // Source coordinates are signed and one bit wider than an address so that
    // taps left of / above the image come out negative.
    localparam int SW = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]    IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]    OUT_W_A    = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0]    OUT_X_LAST = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0]    OUT_Y_LAST = ADDR_W'(OUT_H - 1);
    localparam logic [TAP_W-1:0]     K_T        = TAP_W'(K);
    localparam logic [TAP_W-1:0]     K_LAST     = TAP_W'(K - 1);
    localparam logic signed [SW-1:0] PAD_S      = SW'(PAD);
`ifdef CONV_PAD_EN
    localparam logic signed [SW-1:0] IMG_W_S    = SW'(IMG_W);
    localparam logic signed [SW-1:0] IMG_H_S    = SW'(IMG_H);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;

    // Window position (ox, oy) and tap position (kx, ky) of the tap currently
    // presented on rd_en/rd_addr/tap_idx.
    logic [ADDR_W-1:0] ox;
    logic [ADDR_W-1:0] oy;
    logic [TAP_W-1:0]  kx;
    logic [TAP_W-1:0]  ky;

    // Tap strobes travelling alongside the read, one stage ahead of the MAC.
    logic vld_p0;
    logic first_p0;
    logic last_p0;
`ifdef CONV_PAD_EN
    logic zero_p0;
`endif

    // Next tap to issue and its decoded read.
    logic                     issue;
    logic                     last_tap;
    logic                     last_out;
    logic [ADDR_W-1:0]        sel_ox;
    logic [ADDR_W-1:0]        sel_oy;
    logic [TAP_W-1:0]         sel_kx;
    logic [TAP_W-1:0]         sel_ky;
    logic signed [SW-1:0]     row;
    logic signed [SW-1:0]     col;
    logic                     inb;
    logic [ADDR_W-1:0]        addr;
    logic [TAP_W-1:0]         tap_num;
    logic [ADDR_W-1:0]        out_lin;

    function automatic logic signed [SW-1:0] src_coord(
        input logic [ADDR_W-1:0] o,
        input logic [TAP_W-1:0]  k
    );
        return $signed({1'b0, o}) + $signed(SW'(k)) - PAD_S;
    endfunction

    always_comb begin
        sel_ox   = ox;
        sel_oy   = oy;
        sel_kx   = kx;
        sel_ky   = ky;
        issue    = 1'b0;
        last_tap = (kx == K_LAST) && (ky == K_LAST);
        last_out = (ox == OUT_X_LAST) && (oy == OUT_Y_LAST);

        case (state)
            S_IDLE: begin
                if (start) begin
                    issue  = 1'b1;
                    sel_ox = '0;
                    sel_oy = '0;
                    sel_kx = '0;
                    sel_ky = '0;
                end
            end
            S_FETCH: begin
                if (!last_tap) begin
                    issue = 1'b1;
                    if (kx == K_LAST) begin
                        sel_kx = '0;
                        sel_ky = ky + 1'b1;
                    end else begin
                        sel_kx = kx + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (ox == OUT_X_LAST) begin
                    sel_ox = '0;
                    sel_oy = oy + 1'b1;
                end else begin
                    sel_ox = ox + 1'b1;
                end
                sel_kx = '0;
                sel_ky = '0;
                if (out_ready && !last_out) begin
                    issue = 1'b1;
                end
            end
            default: ;
        endcase

        row = src_coord(sel_oy, sel_ky);
        col = src_coord(sel_ox, sel_kx);
`ifdef CONV_PAD_EN
        inb = (row >= 0) && (row < IMG_H_S) && (col >= 0) && (col < IMG_W_S);
`else
        // Without padding the coordinates are never negative.
        inb = !row[SW-1] && !col[SW-1];
`endif
        addr    = inb ? ADDR_W'(row[ADDR_W-1:0] * IMG_W_A + col[ADDR_W-1:0]) : '0;
        tap_num = TAP_W'(sel_ky * K_T + sel_kx);
        out_lin = ADDR_W'(oy * OUT_W_A + ox);
    end

`ifndef CONV_PAD_EN
    assign tap_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ox        <= '0;
            oy        <= '0;
            kx        <= '0;
            ky        <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            tap_idx   <= '0;
            vld_p0    <= 1'b0;
            first_p0  <= 1'b0;
            last_p0   <= 1'b0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            mac_last  <= 1'b0;
`ifdef CONV_PAD_EN
            zero_p0   <= 1'b0;
            tap_zero  <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // ---- stage p0 -> p1: MAC strobes trail the read by the RAM latency
            mac_en    <= vld_p0;
            mac_clear <= first_p0;
            mac_last  <= last_p0;
`ifdef CONV_PAD_EN
            tap_zero  <= zero_p0;
`endif

            // ---- stage p0: tap issue
            rd_en    <= 1'b0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
`ifdef CONV_PAD_EN
            zero_p0  <= 1'b0;
`endif
            if (issue) begin
                ox       <= sel_ox;
                oy       <= sel_oy;
                kx       <= sel_kx;
                ky       <= sel_ky;
                rd_en    <= inb;
                rd_addr  <= addr;
                tap_idx  <= tap_num;
                vld_p0   <= 1'b1;
                first_p0 <= (sel_kx == '0) && (sel_ky == '0);
                last_p0  <= (sel_kx == K_LAST) && (sel_ky == K_LAST);
`ifdef CONV_PAD_EN
                zero_p0  <= !inb;
`endif
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (last_tap) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state     <= S_EMIT;
                    out_valid <= 1'b1;
                    out_addr  <= out_lin;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_out) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
`timescale 1ns/1ps
module tb_conv_window_scheduler;

    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int K      = 3;
    localparam int ADDR_W = 8;
    localparam int TAP_W  = 4;
    localparam int PER    = K * K + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [TAP_W-1:0]  tap_idx;
    logic              mac_en;
    logic              mac_clear;
    logic              mac_last;
    logic              tap_zero;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;
    logic              busy;
    logic              done;

    conv_window_scheduler #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .ADDR_W(ADDR_W),
        .TAP_W (TAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .tap_idx  (tap_idx),
        .mac_en   (mac_en),
        .mac_clear(mac_clear),
        .mac_last (mac_last),
        .tap_zero (tap_zero),
        .out_valid(out_valid),
        .out_addr (out_addr),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame observations gathered by walk()
    int   n_acc;
    int   acc_addr [0:31];
    int   acc_cyc  [0:31];
    int   done_cnt;
    int   done_cyc;
    int   align_err;
    int   emit_err;
    int   bp_err;
    int   resume_cyc;
    int   timeout;
    int   mc1;
    logic w0_rd   [0:8];
    int   w0_addr [0:8];
    int   w0_tap  [0:8];
    logic w0_zero [0:8];
    logic wl_rd   [0:8];
    int   wl_addr [0:8];
    logic wl_zero [0:8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Observes one frame starting in its first FETCH cycle (c = 0), driving
    // out_ready (optionally withholding it at output bp_out for bp_len cycles)
    // and optionally pulsing start during the first EMIT. Returns at done.
    task automatic walk(input int bp_out, input int bp_len, input bit start_emit,
                        input int win_l, input int max_cyc);
        int         c;
        int         held;
        int         acc_bp;
        int         base;
        bit         pulsed;
        logic       prev_rd;
        int         prev_tap;
        n_acc = 0; done_cnt = 0; done_cyc = -1; align_err = 0; emit_err = 0;
        bp_err = 0; resume_cyc = -1; timeout = 0; mc1 = -1;
        c = 0; held = 0; acc_bp = -1; pulsed = 1'b0; prev_rd = 1'b0; prev_tap = 0;
        base = PER * win_l;
        out_ready = 1'b1;
        while (1) begin
            if (c < 9) begin
                w0_rd[c] = rd_en; w0_addr[c] = int'(rd_addr); w0_tap[c] = int'(tap_idx);
            end
            if (c >= 1 && c <= 9) w0_zero[c-1] = tap_zero;
            if (c >= base && c < base + 9) begin
                wl_rd[c-base] = rd_en; wl_addr[c-base] = int'(rd_addr);
            end
            if (c >= base + 1 && c <= base + 9) wl_zero[c-base-1] = tap_zero;
            if (c == 1) mc1 = int'({mac_en, mac_clear});
            if (mac_en !== prev_rd ||
                mac_clear !== (prev_rd && prev_tap == 0) ||
                mac_last !== (prev_rd && prev_tap == K * K - 1))
                align_err++;
            if (out_valid && (rd_en || mac_en)) emit_err++;
            if (acc_bp >= 0 && resume_cyc < 0 && rd_en) resume_cyc = c;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                break;
            end
            if (c >= max_cyc) begin
                timeout = 1;
                break;
            end
            if (start_emit && pulsed) start = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                if (n_acc == bp_out && held < bp_len) begin
                    out_ready = 1'b0;
                    held++;
                    if (int'(out_addr) != bp_out) bp_err++;
                end else begin
                    acc_addr[n_acc] = int'(out_addr);
                    acc_cyc[n_acc]  = c;
                    if (n_acc == bp_out) acc_bp = c;
                    n_acc++;
                end
                if (start_emit && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
            end
            prev_rd  = rd_en;
            prev_tap = int'(tap_idx);
            step();
            c++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({rd_en, rd_addr, tap_idx, mac_en, mac_clear, mac_last, tap_zero,
             out_valid, out_addr, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rd_en=%b rd_addr=%0d tap=%0d mac=%b%b%b z=%b ov=%b oa=%0d busy=%b done=%b expected all 0",
                     rd_en, rd_addr, tap_idx, mac_en, mac_clear, mac_last, tap_zero,
                     out_valid, out_addr, busy, done);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
    endtask

`ifndef CONV_PAD_EN
    task automatic check_frame(input string name, input int exp_done);
        checks++;
        if (timeout != 0 || done_cnt != 1 || done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s_done got timeout=%0d done_cnt=%0d done_cyc=%0d expected 0 1 %0d",
                     name, timeout, done_cnt, done_cyc, exp_done);
        end
        checks++;
        if (n_acc != 9) begin
            failures++;
            $display("FAIL %s_count got %0d expected 9", name, n_acc);
        end
        checks++;
        if (align_err != 0 || emit_err != 0) begin
            failures++;
            $display("FAIL %s_align got align_err=%0d emit_err=%0d expected 0 0",
                     name, align_err, emit_err);
        end
    endtask

    task automatic test_valid_frame();
        int exp_addr [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        pulse_start();
        walk(99, 0, 1'b0, 0, 300);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (w0_rd[i] !== 1'b1 || w0_addr[i] != exp_addr[i] || w0_tap[i] != i) begin
                failures++;
                $display("FAIL first_window tap=%0d got rd_en=%b addr=%0d idx=%0d expected 1 %0d %0d",
                         i, w0_rd[i], w0_addr[i], w0_tap[i], exp_addr[i], i);
            end
        end
        checks++;
        if (mc1 != 3) begin
            failures++;
            $display("FAIL first_mac got {mac_en,mac_clear}=%0d expected 3", mc1);
        end
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (acc_addr[n] != n || acc_cyc[n] != PER * n + 10) begin
                failures++;
                $display("FAIL output_%0d got addr=%0d cyc=%0d expected %0d %0d",
                         n, acc_addr[n], acc_cyc[n], n, PER * n + 10);
            end
        end
        check_frame("valid_frame", 99);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        pulse_start();
        walk(4, 3, 1'b0, 0, 300);
        check_frame("backpressure", 102);
        checks++;
        if (bp_err != 0 || acc_addr[4] != 4 || acc_cyc[4] != 57) begin
            failures++;
            $display("FAIL bp_hold got bp_err=%0d addr=%0d acc_cyc=%0d expected 0 4 57",
                     bp_err, acc_addr[4], acc_cyc[4]);
        end
        checks++;
        if (resume_cyc != 58 || acc_cyc[5] != 68) begin
            failures++;
            $display("FAIL bp_resume got fetch=%0d out5_cyc=%0d expected 58 68",
                     resume_cyc, acc_cyc[5]);
        end
    endtask

    task automatic test_reset_mid();
        int viol = 0;
        pulse_start();
        repeat (35) step();
        rst = 1'b1;
        step();
        checks++;
        if ({rd_en, rd_addr, tap_idx, mac_en, mac_clear, mac_last, tap_zero,
             out_valid, out_addr, busy, done} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rd_en=%b rd_addr=%0d tap=%0d mac_en=%b ov=%b busy=%b expected all 0",
                     rd_en, rd_addr, tap_idx, mac_en, out_valid, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || out_valid || rd_en || busy) viol++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet got %0d active cycles expected 0", viol);
        end
        pulse_start();
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0 || tap_idx !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart got rd_en=%b addr=%0d idx=%0d busy=%b expected 1 0 0 1",
                     rd_en, rd_addr, tap_idx, busy);
        end
        walk(99, 0, 1'b0, 0, 300);
        check_frame("restart_frame", 99);
        step();
    endtask

    task automatic test_start_in_emit();
        int viol = 0;
        pulse_start();
        walk(99, 0, 1'b1, 0, 300);
        check_frame("start_in_emit", 99);
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || rd_en) viol++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL start_in_emit_idle got %0d active cycles expected 0", viol);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        walk(99, 0, 1'b0, 0, 300);
        check_frame("b2b_first", 99);
        step();
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
        step();
        start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_relaunch got rd_en=%b addr=%0d busy=%b expected 1 0 1",
                     rd_en, rd_addr, busy);
        end
        walk(99, 0, 1'b0, 0, 300);
        check_frame("b2b_second", 99);
        for (int n = 0; n < 9; n++) begin
            checks++;
            if (acc_addr[n] != n) begin
                failures++;
                $display("FAIL b2b_out_%0d got %0d expected %0d", n, acc_addr[n], n);
            end
        end
        step();
    endtask
`else
    task automatic test_padding();
        bit z0 [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
        int a0 [9] = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
        bit zl [9] = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
        int al [9] = '{18, 19, 0, 23, 24, 0, 0, 0, 0};
        pulse_start();
        walk(99, 0, 1'b0, 24, 500);
        checks++;
        if (timeout != 0 || done_cnt != 1 || done_cyc != 25 * PER || n_acc != 25) begin
            failures++;
            $display("FAIL pad_frame got timeout=%0d done_cnt=%0d done_cyc=%0d outputs=%0d expected 0 1 %0d 25",
                     timeout, done_cnt, done_cyc, n_acc, 25 * PER);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (w0_rd[i] !== !z0[i] || w0_zero[i] !== z0[i] || (!z0[i] && w0_addr[i] != a0[i])) begin
                failures++;
                $display("FAIL pad_out0 tap=%0d got rd_en=%b zero=%b addr=%0d expected %b %b %0d",
                         i, w0_rd[i], w0_zero[i], w0_addr[i], !z0[i], z0[i], a0[i]);
            end
            checks++;
            if (wl_rd[i] !== !zl[i] || wl_zero[i] !== zl[i] || (!zl[i] && wl_addr[i] != al[i])) begin
                failures++;
                $display("FAIL pad_out24 tap=%0d got rd_en=%b zero=%b addr=%0d expected %b %b %0d",
                         i, wl_rd[i], wl_zero[i], wl_addr[i], !zl[i], zl[i], al[i]);
            end
        end
        for (int n = 0; n < 25; n++) begin
            checks++;
            if (acc_addr[n] != n) begin
                failures++;
                $display("FAIL pad_out_%0d got %0d expected %0d", n, acc_addr[n], n);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        test_reset();
`ifndef CONV_PAD_EN
        test_valid_frame();
        test_backpressure();
        test_reset_mid();
        test_start_in_emit();
        test_back_to_back();
`else
        test_padding();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequences the convolution datapath over every output pixel of a feature map. Once the input RAM is loaded, it walks a K×K window across the image. For each tap it issues an IFMD RAM read address and a kernel tap index, then drives MAC clear/enable/last strobes aligned to the RAM's 1-cycle read latency. It hands each finished output address to the output RAM with a valid/ready handshake. It sits between the top-level FSM (`start`/`done`) and the IFMD RAM, kernel ROM, MAC and output RAM.

## Interface
- `IMG_W`, 8: input feature map width in pixels (≥ K).
- `IMG_H`, 8: input feature map height in pixels (≥ K).
- `K`, 3: kernel side; odd, ≥ 1.
- `ADDR_W`, 8: width of `rd_addr`/`out_addr`; must hold IMG_W·IMG_H−1.
- `TAP_W`, 4: width of `tap_idx`; must hold K·K−1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `rd_en` out 1: IFMD RAM read strobe.
- `rd_addr` out ADDR_W: IFMD address, row·IMG_W+col.
- `tap_idx` out TAP_W: kernel coefficient index, ky·K+kx; valid with `rd_en` cycle.
- `mac_en` out 1: MAC accumulate this cycle (RAM data valid).
- `mac_clear` out 1: with first `mac_en` of a window; MAC loads the product instead of accumulating.
- `mac_last` out 1: with final `mac_en` of a window.
- `tap_zero` out 1: with `mac_en`; tap is padding, MAC adds 0.
- `out_valid` out 1: output result ready.
- `out_addr` out ADDR_W: oy·OUT_W+ox.
- `out_ready` in 1: output RAM accepts.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after final output accepted.

## Operation
- States: IDLE, FETCH, WAIT, EMIT, DONE.
  - IDLE: `start`=1 → FETCH; clear ox, oy, ky, kx.
  - FETCH: one tap per cycle, kx fastest, K·K cycles. After the tap (K−1,K−1) → WAIT.
  - WAIT: one cycle. The last tap's `mac_en`/`mac_last` fire here. → EMIT.
  - EMIT: `out_valid`=1, `out_addr` stable.
    - On `out_valid`&&`out_ready`: advance ox (wrapping to 0 and incrementing oy at OUT_W−1).
    - If the accepted output was (OUT_W−1, OUT_H−1) → DONE; else → FETCH.
  - DONE: `done`=1 for one cycle → IDLE.
- Tap source coordinates:
  - Without padding: row=oy+ky, col=ox+kx.
  - With padding: row=oy+ky−P, col=ox+kx−P, P=(K−1)/2, computed in signed arithmetic one bit wider than ADDR_W.
- Out-of-bounds tap (padding only): `rd_en`=0, `rd_addr` don't-care; `tap_zero`=1 on the matching `mac_en` cycle.
- `mac_en`, `mac_clear`, `mac_last`, `tap_zero` are registered copies of the FETCH-cycle tap strobes, delayed exactly 1 cycle.
- `start` is ignored outside IDLE. `start` held high after `done` begins a new frame.
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-frame discards the frame, with no `done` and no further `out_valid`.

## Timing
- `start` sampled high at edge t: first `rd_en` at cycle t+1; `mac_en`+`mac_clear` at t+2.
- Per output with `out_ready`=1: K·K FETCH + 1 WAIT + 1 EMIT = K·K+2 cycles.
- `out_valid` is asserted the cycle after `mac_last`. It holds with `out_addr` constant until accepted; no RAM reads occur during EMIT.
- `done` is asserted the cycle after the final handshake.
- Frame cycles with `out_ready`=1: OUT_W·OUT_H·(K·K+2)+1 from the first FETCH cycle, including DONE.

## Configuration
- `CONV_PAD_EN` defined: "same" padding. OUT_W=IMG_W, OUT_H=IMG_H; out-of-bounds taps produce `tap_zero`.
- `CONV_PAD_EN` undefined: "valid" convolution. OUT_W=IMG_W−K+1, OUT_H=IMG_H−K+1; `tap_zero` is tied 0 and every tap issues `rd_en`.

## Test plan
- No padding, IMG 5×5, K=3, `out_ready`=1, `start` pulse:
  - First window `rd_addr` 0,1,2,5,6,7,10,11,12 with `tap_idx` 0..8.
  - 9 outputs, `out_addr` 0..8, 11 cycles apart.
  - `done` pulses once; total 100 cycles from the first FETCH.
- Backpressure: hold `out_ready`=0 for 3 cycles at output 4. `out_valid` stays high with `out_addr`=4, no `rd_en`/`mac_en` occurs, and output 5's FETCH starts the cycle after acceptance.
- Latency alignment: check every `mac_en` is exactly 1 cycle after its `rd_en` tap; `mac_clear` on tap 0 and `mac_last` on tap 8 of every window.
- `CONV_PAD_EN`, IMG 5×5, K=3:
  - 25 outputs.
  - Output 0 taps 0,1,2,3,6 give `tap_zero`=1 with `rd_en`=0; taps 4,5,7,8 read addresses 0,1,5,6.
  - Output 24 taps 2,5,6,7,8 give `tap_zero`=1.
- Assert `rst` during FETCH of output 3. The next cycle has all outputs 0 and state IDLE; no `done` occurs. A later `start` restarts at `rd_addr` 0.
- Pulse `start` during EMIT: it is ignored and the frame completes normally. `start` held high through `done` launches a second identical frame.
